coreboard1588_bram_arbiter: RTL

- Shares the single 16-bit BRAM write port between the two sample streams: S00 (ADS868x) and S01 (ADS124x), each 32-bit AXI4-Stream.
- Arbitrates round-robin at beat granularity and splits each accepted 32-bit beat into two 16-bit BRAM writes.
- Each stream owns one half of the BRAM, used as a ring buffer.
- Signals software by IRQ each time a stream completes half of its region (ping-pong).

---
 rtl/coreboard1588_bram_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/coreboard1588_bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : coreboard1588_bram_arbiter
// Purpose  : Round-robin merge of two 32-bit sample streams into one 16-bit
//            BRAM write port. Each stream writes a ring buffer in its own half.
// Revision : 1.0  initial release
// ============================================================================
module coreboard1588_bram_arbiter #(
    parameter int C_BRAM_ADDR_WIDTH = 12
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         ctrl_enable,
    input  logic [31:0]                  s00_axis_tdata,
    input  logic                         s00_axis_tvalid,
    output logic                         s00_axis_tready,
    input  logic [31:0]                  s01_axis_tdata,
    input  logic                         s01_axis_tvalid,
    output logic                         s01_axis_tready,
    output logic                         bram_clk,
    output logic                         bram_rst,
    output logic [C_BRAM_ADDR_WIDTH-1:0] bram_addr,
    output logic                         bram_en,
    output logic [15:0]                  bram_din,
    output logic [1:0]                   bram_we,
    output logic [C_BRAM_ADDR_WIDTH-2:0] stat_wr_ptr0,
    output logic [C_BRAM_ADDR_WIDTH-2:0] stat_wr_ptr1,
    output logic [1:0]                   stat_half,
    output logic                         ts_irq
);

    localparam int                 c_ptr_w   = C_BRAM_ADDR_WIDTH - 1;
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_two = c_ptr_w'(2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR_LO = 2'd1,
        ST_WR_HI = 2'd2
    } state_t;

    state_t                        r_state;
    state_t                        w_state_next;

    logic [c_ptr_w-1:0]            r_ptr0;
    logic [c_ptr_w-1:0]            r_ptr1;
    logic [1:0]                    r_half;
    logic                          r_last_grant;
    logic [31:0]                   r_data;
    logic                          r_sid;
    logic                          r_irq;
    logic                          r_bram_en;
    logic [1:0]                    r_bram_we;
    logic [C_BRAM_ADDR_WIDTH-1:0]  r_bram_addr;
    logic [15:0]                   r_bram_din;

    logic                          w_can_accept;
    logic                          w_sel00;
    logic                          w_sel01;
    logic                          w_accept;
    logic                          w_gnt_sid;
    logic [31:0]                   w_gnt_data;
    logic [c_ptr_w-1:0]            w_ptr_cur;
    logic [c_ptr_w-1:0]            w_ptr_inc;
    logic [c_ptr_w-1:0]            w_ptr0_next;
    logic [c_ptr_w-1:0]            w_ptr1_next;
    logic [c_ptr_w-1:0]            w_gnt_ptr;
    logic                          w_half_done;
    logic                          w_bram_en_next;
    logic [1:0]                    w_bram_we_next;
    logic [C_BRAM_ADDR_WIDTH-1:0]  w_bram_addr_next;
    logic [15:0]                   w_bram_din_next;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_ptr0_next      = r_ptr0;
        w_ptr1_next      = r_ptr1;
        w_half_done      = 1'b0;
        w_bram_en_next   = 1'b0;
        w_bram_we_next   = 2'b00;
        w_bram_addr_next = '0;
        w_bram_din_next  = 16'h0000;

        // Tie-break favours the stream that did not win last; a lone valid wins outright.
        w_can_accept = aresetn && ctrl_enable &&
                       ((r_state == ST_IDLE) || (r_state == ST_WR_HI));
        w_sel00      = s00_axis_tvalid && (!s01_axis_tvalid || r_last_grant);
        w_sel01      = s01_axis_tvalid && (!s00_axis_tvalid || !r_last_grant);
        s00_axis_tready = w_can_accept && w_sel00;
        s01_axis_tready = w_can_accept && w_sel01;
        w_accept     = s00_axis_tready || s01_axis_tready;
        w_gnt_sid    = w_sel01;
        w_gnt_data   = w_sel01 ? s01_axis_tdata : s00_axis_tdata;

        w_ptr_cur    = r_sid ? r_ptr1 : r_ptr0;
        w_ptr_inc    = w_ptr_cur + c_ptr_two;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_WR_LO;
                end
                if (!ctrl_enable) begin
                    w_ptr0_next = '0;
                    w_ptr1_next = '0;
                end
            end
            ST_WR_LO: begin
                w_state_next = ST_WR_HI;
            end
            ST_WR_HI: begin
                if (r_sid) begin
                    w_ptr1_next = w_ptr_inc;
                end else begin
                    w_ptr0_next = w_ptr_inc;
                end
                w_half_done  = (w_ptr_inc[c_ptr_w-2:0] == '0);
                w_state_next = w_accept ? ST_WR_LO : ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // The BRAM port is registered, so the write for the coming state is built
        // here; a back-to-back beat of the same stream must see the bumped pointer.
        w_gnt_ptr = w_gnt_sid ? w_ptr1_next : w_ptr0_next;
        if (w_accept) begin
            w_bram_en_next   = 1'b1;
            w_bram_we_next   = 2'b11;
            w_bram_addr_next = {w_gnt_sid, w_gnt_ptr};
            w_bram_din_next  = w_gnt_data[15:0];
        end else if (r_state == ST_WR_LO) begin
            w_bram_en_next   = 1'b1;
            w_bram_we_next   = 2'b11;
            w_bram_addr_next = {r_sid, w_ptr_cur + c_ptr_one};
            w_bram_din_next  = r_data[31:16];
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_ptr0       <= '0;
            r_ptr1       <= '0;
            r_half       <= 2'b00;
            r_last_grant <= 1'b1;
            r_data       <= 32'h0000_0000;
            r_sid        <= 1'b0;
            r_irq        <= 1'b0;
            r_bram_en    <= 1'b0;
            r_bram_we    <= 2'b00;
            r_bram_addr  <= '0;
            r_bram_din   <= 16'h0000;
        end else begin
            r_ptr0 <= w_ptr0_next;
            r_ptr1 <= w_ptr1_next;
            r_irq  <= w_half_done;
            if (w_half_done) begin
                r_half[r_sid] <= ~w_ptr_inc[c_ptr_w-1];
            end
            if (w_accept) begin
                r_data       <= w_gnt_data;
                r_sid        <= w_gnt_sid;
                r_last_grant <= w_gnt_sid;
            end
            r_bram_en   <= w_bram_en_next;
            r_bram_we   <= w_bram_we_next;
            r_bram_addr <= w_bram_addr_next;
            r_bram_din  <= w_bram_din_next;
        end
    end

    assign bram_clk     = aclk;
    assign bram_rst     = ~aresetn;
    assign bram_en      = r_bram_en;
    assign bram_we      = r_bram_we;
    assign bram_addr    = r_bram_addr;
    assign bram_din     = r_bram_din;
    assign stat_wr_ptr0 = r_ptr0;
    assign stat_wr_ptr1 = r_ptr1;
    assign stat_half    = r_half;
    assign ts_irq       = r_irq;

endmodule
`default_nettype wire
